// File: rtl/image_window_reader_if.sv
// Memory read port and window output stream of the 3x3 image window reader.
// The master side is the reader; the slave side is the image memory plus the downstream stage.
interface image_window_reader_if #(
   parameter int addressWidthImg = 10,
   parameter int dataWidthImg    = 16
);
   logic                       ren;
   logic [addressWidthImg-1:0] addr1;
   logic [addressWidthImg-1:0] addr2;
   logic [dataWidthImg-1:0]    rdata0, rdata1, rdata2, rdata3, rdata4, rdata5, rdata6, rdata7, rdata8;
   logic [dataWidthImg-1:0]    win0, win1, win2, win3, win4, win5, win6, win7, win8;
   logic [addressWidthImg-1:0] out_row;
   logic [addressWidthImg-1:0] out_col;
   logic                       out_valid;
   logic                       out_ready;

   modport master (
      output ren, addr1, addr2,
      input  rdata0, rdata1, rdata2, rdata3, rdata4, rdata5, rdata6, rdata7, rdata8,
      output win0, win1, win2, win3, win4, win5, win6, win7, win8,
      output out_row, out_col, out_valid,
      input  out_ready
   );

   modport slave (
      input  ren, addr1, addr2,
      output rdata0, rdata1, rdata2, rdata3, rdata4, rdata5, rdata6, rdata7, rdata8,
      input  win0, win1, win2, win3, win4, win5, win6, win7, win8,
      input  out_row, out_col, out_valid,
      output out_ready
   );
endinterface

// File: rtl/image_window_reader.sv
// Scans every 3x3 window position of a loaded image, reads it from the window memory
// and hands each captured window with its row/column tag to the downstream stage.
//
// state     | meaning
// IDLE      | waiting for start
// WAIT_FULL | scan requested, waiting for the memory to report full
// READ      | ren asserted for the current window position
// CAPT      | memory data valid, capture window and tags
// HOLD      | window presented, waiting for out_ready
// DONE      | one-cycle completion pulse
module image_window_reader #(
   parameter int n_c             = 28,
   parameter int n_r             = 28,
   parameter int addressWidthImg = 10,
   parameter int dataWidthImg    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mem_full,
   output logic                  busy,
   output logic                  done,
   image_window_reader_if.master bus
);
   localparam logic [addressWidthImg-1:0] last_row = addressWidthImg'(n_r - 3);
   localparam logic [addressWidthImg-1:0] last_col = addressWidthImg'(n_c - 3);

   typedef enum logic [2:0] {IDLE, WAIT_FULL, READ, CAPT, HOLD, DONE} state_t;

   state_t                     state_q, state_d;
   logic [addressWidthImg-1:0] row_q, col_q;
   logic                       clr_cnt, adv_cnt;
   logic                       accept, last_pos;

   assign accept   = bus.out_valid && bus.out_ready;
   assign last_pos = (row_q == last_row) && (col_q == last_col);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      clr_cnt = 1'b0;
      adv_cnt = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               clr_cnt = 1'b1;
               state_d = mem_full ? READ : WAIT_FULL;
            end
         end
         WAIT_FULL: if (mem_full) state_d = READ;
         READ:      state_d = CAPT;
         CAPT:      state_d = HOLD;
         HOLD: begin
            if (accept) begin
               if (last_pos) begin
                  state_d = DONE;
               end else begin
                  adv_cnt = 1'b1;
                  state_d = READ;
               end
            end
         end
         DONE:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Counters double as the registered read address, so addr1/addr2 are stable through READ.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q <= '0;
         col_q <= '0;
      end else if (clr_cnt) begin
         row_q <= '0;
         col_q <= '0;
      end else if (adv_cnt) begin
         if (col_q == last_col) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
         end else begin
            col_q <= col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_row   <= '0;
         bus.out_col   <= '0;
         bus.win0 <= '0; bus.win1 <= '0; bus.win2 <= '0;
         bus.win3 <= '0; bus.win4 <= '0; bus.win5 <= '0;
         bus.win6 <= '0; bus.win7 <= '0; bus.win8 <= '0;
      end else if (state_q == CAPT) begin
         bus.out_valid <= 1'b1;
         bus.out_row   <= row_q;
         bus.out_col   <= col_q;
         bus.win0 <= bus.rdata0; bus.win1 <= bus.rdata1; bus.win2 <= bus.rdata2;
         bus.win3 <= bus.rdata3; bus.win4 <= bus.rdata4; bus.win5 <= bus.rdata5;
         bus.win6 <= bus.rdata6; bus.win7 <= bus.rdata7; bus.win8 <= bus.rdata8;
      end else if (accept) begin
         bus.out_valid <= 1'b0;
      end
   end

   assign bus.ren   = (state_q == READ);
   assign bus.addr1 = row_q;
   assign bus.addr2 = col_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
endmodule
